// File: rtl/pblaze_io_hub.sv
// rtl/pblaze_io_hub.sv - KCPSM6 port bus hub: output registers, input mux, edge-triggered interrupts
module pblaze_io_hub #(
   parameter int         N_OUT    = 4,
   parameter int         N_IN     = 4,
   parameter int         N_IRQ    = 4,
   parameter logic [7:0] OUT_BASE = 8'h00,
   parameter logic [7:0] IN_BASE  = 8'h20,
   parameter logic [7:0] IRQ_BASE = 8'hF0,
   parameter int         K_ENABLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           port_id,
   input  logic [7:0]           out_port,
   input  logic                 write_strobe,
   input  logic                 k_write_strobe,
   input  logic                 read_strobe,
   output logic [7:0]           in_port,
   output logic                 interrupt,
   input  logic                 interrupt_ack,
   input  logic [8*N_IN-1:0]    ext_in,
   output logic [8*N_OUT-1:0]   ext_out,
   output logic [N_OUT-1:0]     out_stb,
   input  logic [N_IRQ-1:0]     irq_src
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state;
   logic [N_IRQ-1:0] irq_sync, irq_prev, pending, mask, rise;
   logic [N_OUT-1:0] wr_hit;
   logic [7:0]       out_off, in_off, rd_data;
   logic             clr_wr, mask_wr, req;
   logic             unused_read_strobe;

   // read_strobe is part of the bus but reads carry no side effects
   assign unused_read_strobe = read_strobe;

   assign out_off = port_id - OUT_BASE;
   assign in_off  = port_id - IN_BASE;

   // OUTPUTK decodes only the low nibble of port_id
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (write_strobe && out_off == 8'(i))
            wr_hit[i] = 1'b1;
         if (K_ENABLE != 0 && k_write_strobe && port_id[3:0] == 4'(i))
            wr_hit[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_out <= '0;
         out_stb <= '0;
      end else begin
         out_stb <= wr_hit;
         for (int i = 0; i < N_OUT; i++)
            if (wr_hit[i])
               ext_out[8*i +: 8] <= out_port;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (port_id == IRQ_BASE) begin
         rd_data[N_IRQ-1:0] = pending;
      end else if (port_id == IRQ_BASE + 8'd1) begin
         rd_data[N_IRQ-1:0] = mask;
      end else begin
         for (int j = 0; j < N_IN; j++)
            if (in_off == 8'(j))
               rd_data = ext_in[8*j +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         in_port <= 8'h00;
      else
         in_port <= rd_data;
   end

   assign rise    = irq_sync & ~irq_prev;
   assign clr_wr  = write_strobe && (port_id == IRQ_BASE);
   assign mask_wr = write_strobe && (port_id == IRQ_BASE + 8'd1);
   assign req     = |(pending & mask);

   // a new edge overrides a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_sync <= '0;
         irq_prev <= '0;
         pending  <= '0;
         mask     <= '0;
      end else begin
         irq_sync <= irq_src;
         irq_prev <= irq_sync;
         if (clr_wr)
            pending <= (pending & ~out_port[N_IRQ-1:0]) | rise;
         else
            pending <= pending | rise;
         if (mask_wr)
            mask <= out_port[N_IRQ-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (req) state <= S_REQ;
            S_REQ:   if (interrupt_ack) state <= S_HOLD;
            S_HOLD:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign interrupt = (state == S_REQ);

endmodule

// File: tb/tb_pblaze_io_hub.sv
// tb/tb_pblaze_io_hub.sv - self-checking bench for pblaze_io_hub
module tb_pblaze_io_hub;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  port_id, out_port;
   logic        write_strobe, k_write_strobe, read_strobe, interrupt_ack;
   logic [31:0] ext_in;
   logic [3:0]  irq_src;

   logic [7:0]  in_port_a, in_port_b;
   logic        interrupt_a, interrupt_b;
   logic [31:0] ext_out_a, ext_out_b;
   logic [3:0]  out_stb_a, out_stb_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pblaze_io_hub #(.K_ENABLE(1)) dut_a (
      .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
      .read_strobe(read_strobe), .in_port(in_port_a), .interrupt(interrupt_a),
      .interrupt_ack(interrupt_ack), .ext_in(ext_in), .ext_out(ext_out_a),
      .out_stb(out_stb_a), .irq_src(irq_src)
   );

   pblaze_io_hub #(.K_ENABLE(0)) dut_b (
      .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
      .read_strobe(read_strobe), .in_port(in_port_b), .interrupt(interrupt_b),
      .interrupt_ack(interrupt_ack), .ext_in(ext_in), .ext_out(ext_out_b),
      .out_stb(out_stb_b), .irq_src(irq_src)
   );

   // behavioural model: register file, pending/mask words, interrupt line with post-ack cooldown
   logic [7:0] m_out_a [4];
   logic [7:0] m_out_b [4];
   logic [3:0] m_stb_a, m_stb_b, m_pend, m_mask, m_now, m_last;
   logic [7:0] m_in;
   logic       m_int;
   int         m_cool;
   bit         armed = 0;

   always @(posedge clk) begin
      int         a, ki;
      logic [7:0] rd;
      logic       req;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin m_out_a[i] = 0; m_out_b[i] = 0; end
         m_stb_a = 0; m_stb_b = 0; m_pend = 0; m_mask = 0;
         m_now = 0; m_last = 0; m_in = 0; m_int = 0; m_cool = 0;
         armed = 1;
      end else begin
         a  = int'(port_id);
         rd = 8'h00;
         if (a == 240)                rd = {4'h0, m_pend};
         else if (a == 241)           rd = {4'h0, m_mask};
         else if (a >= 32 && a < 36)  rd = ext_in[8*(a-32) +: 8];
         req = (m_pend & m_mask) != 0;
         if (m_int) begin
            if (interrupt_ack) begin m_int = 0; m_cool = 1; end
         end else if (m_cool > 0) begin
            m_cool--;
         end else if (req) begin
            m_int = 1;
         end
         if (write_strobe && a == 240) m_pend = m_pend & ~out_port[3:0];
         m_pend = m_pend | (m_now & ~m_last);
         if (write_strobe && a == 241) m_mask = out_port[3:0];
         m_last = m_now;
         m_now  = irq_src;
         m_stb_a = 0; m_stb_b = 0;
         if (write_strobe && a < 4) begin
            m_out_a[a] = out_port; m_out_b[a] = out_port;
            m_stb_a[a] = 1'b1;     m_stb_b[a] = 1'b1;
         end
         ki = int'(port_id[3:0]);
         if (k_write_strobe && ki < 4) begin
            m_out_a[ki] = out_port; m_stb_a[ki] = 1'b1;
         end
         m_in = rd;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("model in_port",   {24'h0, in_port_a}, {24'h0, m_in});
         chk("model interrupt", {31'h0, interrupt_a}, {31'h0, m_int});
         chk("model ext_out_a", ext_out_a, {m_out_a[3], m_out_a[2], m_out_a[1], m_out_a[0]});
         chk("model ext_out_b", ext_out_b, {m_out_b[3], m_out_b[2], m_out_b[1], m_out_b[0]});
         chk("model out_stb_a", {28'h0, out_stb_a}, {28'h0, m_stb_a});
         chk("model out_stb_b", {28'h0, out_stb_b}, {28'h0, m_stb_b});
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d, input logic k);
      port_id = p; out_port = d;
      if (k) k_write_strobe = 1'b1; else write_strobe = 1'b1;
      step(1);
      write_strobe = 1'b0; k_write_strobe = 1'b0;
   endtask

   task automatic rd(input string name, input logic [7:0] p, input logic [7:0] exp);
      port_id = p;
      step(1);
      chk(name, {24'h0, in_port_a}, {24'h0, exp});
   endtask

   initial begin
      rst = 1'b1; port_id = 0; out_port = 0; write_strobe = 0; k_write_strobe = 0;
      read_strobe = 0; interrupt_ack = 0; ext_in = 32'h7E33_2211; irq_src = 0;
      step(2);
      chk("reset ext_out", ext_out_a, 32'h0);
      chk("reset interrupt", {31'h0, interrupt_a}, 32'h0);
      rst = 1'b0;

      wr(8'h02, 8'hA5, 1'b0);
      chk("out write", ext_out_a, 32'h00A5_0000);
      chk("out stb", {28'h0, out_stb_a}, 32'h4);
      step(1);
      chk("out stb drop", {28'h0, out_stb_a}, 32'h0);

      wr(8'h31, 8'h3C, 1'b1);
      chk("k write a", ext_out_a, 32'h00A5_3C00);
      chk("k write b ignored", ext_out_b, 32'h00A5_0000);
      wr(8'h0F, 8'h99, 1'b1);
      wr(8'h04, 8'h99, 1'b0);
      wr(8'h03, 8'hFF, 1'b0);
      chk("unmapped + top reg", ext_out_a, 32'hFFA5_3C00);

      rd("read ch3", 8'h23, 8'h7E);
      rd("read ch0", 8'h20, 8'h11);
      rd("read past N_IN", 8'h24, 8'h00);
      rd("read unmapped", 8'h40, 8'h00);

      wr(8'hF1, 8'hF2, 1'b0);
      rd("mask readback", 8'hF1, 8'h02);
      port_id = 8'hF0;
      irq_src = 4'b0010;
      step(1);
      irq_src = 4'b0000;
      chk("irq lat1", {31'h0, interrupt_a}, 32'h0);
      step(1);
      chk("irq lat2", {31'h0, interrupt_a}, 32'h0);
      step(1);
      chk("irq lat3", {31'h0, interrupt_a}, 32'h1);
      chk("pending", {24'h0, in_port_a}, 32'h02);
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("irq held", {31'h0, interrupt_a}, 32'h1);
      end
      interrupt_ack = 1'b1;
      step(1);
      interrupt_ack = 1'b0;
      chk("ack drop", {31'h0, interrupt_a}, 32'h0);
      wr(8'hF0, 8'h02, 1'b0);
      port_id = 8'hF0;
      step(1);
      chk("w1c pending", {24'h0, in_port_a}, 32'h00);
      step(3);
      chk("no rerequest", {31'h0, interrupt_a}, 32'h0);

      wr(8'hF1, 8'h04, 1'b0);
      irq_src = 4'b0100;
      step(1);
      irq_src = 4'b0000;
      step(2);
      chk("irq2 up", {31'h0, interrupt_a}, 32'h1);
      interrupt_ack = 1'b1;
      step(1);
      interrupt_ack = 1'b0;
      chk("hold 1", {31'h0, interrupt_a}, 32'h0);
      step(1);
      chk("hold 2", {31'h0, interrupt_a}, 32'h0);
      step(1);
      chk("reassert", {31'h0, interrupt_a}, 32'h1);
      interrupt_ack = 1'b1;
      step(1);
      interrupt_ack = 1'b0;
      wr(8'hF0, 8'h04, 1'b0);
      wr(8'hF1, 8'h00, 1'b0);
      step(2);
      chk("cleared 2", {31'h0, interrupt_a}, 32'h0);

      irq_src = 4'b0001;
      step(2);
      rd("masked pending", 8'hF0, 8'h01);
      chk("masked no irq", {31'h0, interrupt_a}, 32'h0);
      wr(8'hF0, 8'h01, 1'b0);
      rd("w1c bit0", 8'hF0, 8'h00);
      irq_src = 4'b0000;
      step(2);
      irq_src = 4'b0001;
      step(1);
      wr(8'hF0, 8'h01, 1'b0);
      rd("set wins", 8'hF0, 8'h01);

      wr(8'hF1, 8'h01, 1'b0);
      chk("req pre", {31'h0, interrupt_a}, 32'h0);
      step(1);
      chk("req up", {31'h0, interrupt_a}, 32'h1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst interrupt", {31'h0, interrupt_a}, 32'h0);
      chk("rst ext_out", ext_out_a, 32'h0);
      chk("rst out_stb", {28'h0, out_stb_a}, 32'h0);
      rd("rst pending", 8'hF0, 8'h00);
      rd("rst mask", 8'hF1, 8'h00);
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
